// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built from one full-adder cell.
// An accepted operation runs for WIDTH cycles, one bit per cycle from the LSB.
// It then spends one cycle in DONE with a one-cycle done pulse, and sum/c_out
// are loaded on that same edge.
// Optional build macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow
// output (ovf). The default build leaves the macro undefined and has no ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh;      // operand A; result bits shift in at the MSB
  logic [WIDTH-1:0] b_sh;      // operand B, already inverted for subtraction
  logic             carry;     // the single carry flip-flop
  logic [CW-1:0]    cnt;       // index of the bit being processed
  logic             accept;
  logic             last;
  logic             fa_s;
  logic             fa_co;

  // Full-adder cell working on the current LSBs and the stored carry.
  assign fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_co = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last  = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so that every register
    // samples values from before the edge, whatever order the blocks run in.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub | c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= {fa_s, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum   <= {fa_s, a_sh[WIDTH-1:1]};
        c_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        // During the MSB step, carry holds the carry into the MSB.
        ovf   <= carry ^ fa_co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
// Overflow checks are compiled in only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge after the accepting edge. Counts negedges until done
  // is seen and checks that count. With toggle set, the operands change every
  // cycle and start pulses while the operation runs.
  task automatic wait_done(input string tag, input bit toggle, input int exp_lat);
    int lat;
    lat = -1;
    for (int n = 1; n <= 3 * WIDTH; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (toggle) begin
        a     = ~a;
        b     = ~b;
        c_in  = ~c_in;
        start = n[0];
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  // Runs one operation from a negedge and checks the result, the single-cycle
  // done pulse and that the result holds afterwards.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic ts, input logic [WIDTH-1:0] es,
                        input logic ec, input logic eo, input bit toggle);
    a = ta; b = tb; c_in = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_run"}, busy, 1);
    check({tag, "_done_run"}, done, 0);
    if (toggle) begin
      a = ~a; b = ~b; c_in = ~c_in;
    end
    wait_done(tag, toggle, WIDTH);
    start = 1'b0;
    check({tag, "_sum"}, sum, es);
    check({tag, "_c_out"}, c_out, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`endif
    check({tag, "_busy_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, sum, es);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    //     tag           a      b      cin   sub   sum    cout  ovf  toggle
    run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("sub_borrow",8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ok",    8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    run_op("ovf_pos",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("ovf_neg",   8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("sub_cin",   8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("toggle",    8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held high throughout.
    a = 8'h10; b = 8'h20; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h01;
    wait_done("b2b_first", 1'b0, WIDTH);
    check("b2b_first_sum", sum, 8'h30);
    wait_done("b2b_second", 1'b0, WIDTH + 1);
    start = 1'b0;
    check("b2b_second_sum", sum, 8'h02);
    @(negedge clk);
    check("b2b_done_pulse", done, 0);
    check("b2b_idle_busy", busy, 0);

    // Reset in the middle of RUN.
    a = 8'hAA; b = 8'h55; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_c_out", c_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 2 * WIDTH; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_sum_after", sum, 0);
    run_op("after_rst", 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
